spi_log_scheduler: RTL and testbench
====================================

SPI_LOG_SCHEDULER -- requirements
Module: spi_log_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, entries per channel FIFO (power of two, >=2).
REQ-002 fifo_clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  1 = scheduler may start new records.
REQ-005 ch0_data  input  8  channel 0 captured byte.
REQ-006 ch0_valid  input  1  one-cycle strobe, ch0_data valid.
REQ-007 ch1_data  input  8  channel 1 captured byte.
REQ-008 ch1_valid  input  1  one-cycle strobe, ch1_data valid.
REQ-009 uart_busy  input  1  UART transmitter busy.
REQ-010 tx_data  output  8  byte to UART, registered.
REQ-011 tx_start  output  1  one-cycle transmit request, registered.
REQ-012 drop_cnt0  output  8  channel 0 dropped-byte count, saturating.
REQ-013 drop_cnt1  output  8  channel 1 dropped-byte count, saturating.
REQ-014 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-015 Each channel SHALL have an independent DEPTH-entry FIFO; a chN_valid strobe pushes chN_data at that rising edge unless the FIFO is full.
REQ-016 Push to a full FIFO SHALL drop the byte, set channel drop_pending, and increment drop_cntN, saturating at 8'hFF.
REQ-017 Push and pop on the same edge SHALL both take effect; on a full FIFO the push SHALL be accepted and no drop occurs.
REQ-018 Each popped byte SHALL be emitted as a 2-byte record: tag then data.
REQ-019 Tag SHALL be 8'hA0 | (drop_pending<<4) | ch (ch0 = 8'hA0/8'hB0, ch1 = 8'hA1/8'hB1).
REQ-020 drop_pending for a channel SHALL clear at the pop that captures it into the tag; a drop on the same edge SHALL leave it set.
REQ-021 FSM states SHALL be IDLE, TAG, GUARD_T, WAIT_T, DATA, GUARD_D and WAIT_D.
REQ-022 IDLE: when enable=1, uart_busy=0 and a FIFO is non-empty, grant a channel, pop its head into a hold register, latch the tag, and go to TAG.
REQ-023 Arbitration SHALL be round-robin: if both FIFOs are non-empty, grant the channel not granted last; if only one is non-empty, grant it.
REQ-024 TAG: tx_start=1 and tx_data=tag for exactly one cycle, then go to GUARD_T.
REQ-025 GUARD_T: ignore uart_busy for one cycle, then go to WAIT_T.
REQ-026 WAIT_T: stay while uart_busy=1; go to DATA on uart_busy=0.
REQ-027 DATA: tx_start=1 and tx_data=held byte for one cycle, then go to GUARD_D.
REQ-028 GUARD_D: one cycle, then go to WAIT_D.
REQ-029 WAIT_D: go to IDLE on uart_busy=0.
REQ-030 tx_start SHALL be 0 in all states except TAG and DATA.
REQ-031 tx_data SHALL hold its last value outside TAG and DATA.
REQ-032 Latency: with an empty system, enable=1 and uart_busy=0, tx_start for the tag SHALL be high two cycles after the chN_valid cycle.
REQ-033 Deasserting enable mid-record SHALL NOT abort the record; the FSM SHALL complete it and then hold in IDLE.
REQ-034 While enable=0, the FIFOs SHALL still accept pushes.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH, and occupancy SHALL distinguish full from empty.

Reset
REQ-036 reset_n=0 SHALL immediately set: state=IDLE, FIFOs empty, drop_pending=0, drop_cnt0/1=0, tx_start=0, tx_data=8'h00, last grant=ch1 (so ch0 wins the first tie).
REQ-037 Reset mid-record SHALL discard the held byte and all buffered bytes, and SHALL NOT emit tx_start until released.

Verification
REQ-038 ch0 byte 8'h5A, uart_busy=0 -> tx_start with 8'hA0 at +2 cycles; after busy low, tx_start with 8'h5A.
REQ-039 ch0 and ch1 strobe in the same cycle (8'h11, 8'h22) -> records A0/11 then A1/22; further ties alternate.
REQ-040 Ten ch1 strobes while enable=0 (DEPTH=8) -> drop_cnt1=2; on enable, first record 8'hB1, remaining seven 8'hA1, data in push order.
REQ-041 uart_busy held high 20 cycles after tag -> no second tx_start until busy falls; data byte follows then.
REQ-042 Reset asserted in WAIT_T with three ch0 bytes queued -> outputs reset at once; after release, no tx_start without new strobes.
REQ-043 300 ch0 strobes into a full FIFO -> drop_cnt0 saturates at 8'hFF.

Source files
------------

// File: rtl/spi_log_scheduler.sv
// Two-channel byte logger: per-channel FIFOs feed a round-robin scheduler that
// frames each byte as a tag/data record for a UART transmitter.
module spi_log_scheduler #(
    parameter int DEPTH = 8
) (
    input  logic       fifo_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] ch0_data,
    input  logic       ch0_valid,
    input  logic [7:0] ch1_data,
    input  logic       ch1_valid,
    input  logic       uart_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] drop_cnt0,
    output logic [7:0] drop_cnt1
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TAG     = 3'd1;
    localparam logic [2:0] S_GUARD_T = 3'd2;
    localparam logic [2:0] S_WAIT_T  = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_GUARD_D = 3'd5;
    localparam logic [2:0] S_WAIT_D  = 3'd6;

    logic [7:0]      mem_q [2][DEPTH];
    logic [1:0][AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0][7:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]      drop_pend_q, drop_pend_d;
    logic [2:0]      state_q, state_d;
    logic [7:0]      hold_q, hold_d, tag_q, tag_d, tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d, last_q, last_d;

    logic [1:0]      vld_s, full_s, empty_s, push_s, pop_s, drop_s;
    logic [1:0][7:0] din_s;
    logic            grant_s;

    // Channel FIFO status, push acceptance and drop accounting
    always_comb begin
        vld_s = {ch1_valid, ch0_valid};
        din_s = {ch1_data, ch0_data};
        for (int c = 0; c < 2; c++) begin
            empty_s[c] = (wptr_q[c] == rptr_q[c]);
            full_s[c]  = ((wptr_q[c] - rptr_q[c]) == DEPTH_L);
            // A pop on the same edge frees a slot, so a full FIFO still accepts
            push_s[c]  = vld_s[c] & (~full_s[c] | pop_s[c]);
            drop_s[c]  = vld_s[c] & full_s[c] & ~pop_s[c];
            wptr_d[c]  = wptr_q[c] + {{AW{1'b0}}, push_s[c]};
            rptr_d[c]  = rptr_q[c] + {{AW{1'b0}}, pop_s[c]};
            drop_pend_d[c] = drop_s[c] | (drop_pend_q[c] & ~pop_s[c]);
            if (drop_s[c] && (drop_cnt_q[c] != 8'hFF)) begin
                drop_cnt_d[c] = drop_cnt_q[c] + 8'd1;
            end else begin
                drop_cnt_d[c] = drop_cnt_q[c];
            end
        end
    end

    // Round-robin grant: on a tie the channel not served last wins
    always_comb begin
        if (!empty_s[0] && !empty_s[1]) begin
            grant_s = ~last_q;
        end else if (!empty_s[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end

    // Record sequencing FSM; output registers are loaded alongside the state
    always_comb begin
        state_d    = state_q;
        pop_s      = 2'b00;
        hold_d     = hold_q;
        tag_d      = tag_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !uart_busy && (empty_s != 2'b11)) begin
                    pop_s[grant_s] = 1'b1;
                    hold_d     = mem_q[grant_s][rptr_q[grant_s][AW-1:0]];
                    tag_d      = 8'hA0 | {3'b000, drop_pend_q[grant_s], 4'h0} | {7'b0000000, grant_s};
                    last_d     = grant_s;
                    state_d    = S_TAG;
                    tx_start_d = 1'b1;
                    tx_data_d  = tag_d;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TAG:     state_d = S_GUARD_T;
            S_GUARD_T: state_d = S_WAIT_T;
            S_WAIT_T: begin
                if (!uart_busy) begin
                    state_d    = S_DATA;
                    tx_start_d = 1'b1;
                    tx_data_d  = hold_q;
                end else begin
                    state_d = S_WAIT_T;
                end
            end
            S_DATA:    state_d = S_GUARD_D;
            S_GUARD_D: state_d = S_WAIT_D;
            S_WAIT_D: begin
                if (!uart_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_D;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge fifo_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push_s[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= din_s[c];
            end
        end
    end

    // Control and output state registers
    always_ff @(posedge fifo_clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            drop_cnt_q  <= '0;
            drop_pend_q <= 2'b00;
            state_q     <= S_IDLE;
            hold_q      <= 8'h00;
            tag_q       <= 8'h00;
            last_q      <= 1'b1;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_pend_q <= drop_pend_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            tag_q       <= tag_d;
            last_q      <= last_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign drop_cnt0 = drop_cnt_q[0];
    assign drop_cnt1 = drop_cnt_q[1];

endmodule

// File: tb/tb_spi_log_scheduler.sv
// Directed bench for spi_log_scheduler; transmitted bytes are checked against
// a queue of expected record bytes filled when stimulus is applied.
module tb_spi_log_scheduler;

    logic       fifo_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] ch0_data = 8'h00;
    logic       ch0_valid = 1'b0;
    logic [7:0] ch1_data = 8'h00;
    logic       ch1_valid = 1'b0;
    logic       uart_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] drop_cnt0;
    logic [7:0] drop_cnt1;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    spi_log_scheduler #(.DEPTH(8)) dut (
        .fifo_clk(fifo_clk), .reset_n(reset_n), .enable(enable),
        .ch0_data(ch0_data), .ch0_valid(ch0_valid),
        .ch1_data(ch1_data), .ch1_valid(ch1_valid),
        .uart_busy(uart_busy), .tx_data(tx_data), .tx_start(tx_start),
        .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every transmit request must match the next expected byte
    always @(negedge fifo_clk) begin
        if (reset_n && tx_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic expect_rec(input logic [7:0] tag, input logic [7:0] data);
        exp_q.push_back(tag);
        exp_q.push_back(data);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge fifo_clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge fifo_clk);
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (!tx_start && n < 50) begin
            @(negedge fifo_clk);
            n++;
        end
        check(tag, tx_start, 1);
    endtask

    task automatic strobe(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        @(negedge fifo_clk);
        ch0_valid = v0; ch0_data = d0;
        ch1_valid = v1; ch1_data = d1;
        @(negedge fifo_clk);
        ch0_valid = 1'b0; ch1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge fifo_clk);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge fifo_clk);
        reset_n = 1'b1;
        @(negedge fifo_clk);
    endtask

    initial begin
        int early;
        int seen;

        // Reset values
        #2;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_drop_cnt0", drop_cnt0, 8'h00);
        check("rst_drop_cnt1", drop_cnt1, 8'h00);
        repeat (2) @(negedge fifo_clk);
        reset_n = 1'b1;
        enable = 1'b1;
        @(negedge fifo_clk);

        // Single ch0 byte and its two-cycle tag latency
        expect_rec(8'hA0, 8'h5A);
        ch0_valid = 1'b1; ch0_data = 8'h5A;
        @(negedge fifo_clk);
        ch0_valid = 1'b0;
        check("lat_cycle1_idle", tx_start, 0);
        @(negedge fifo_clk);
        check("lat_cycle2_tag", tx_start, 1);
        drain("drain_single");

        // Tie right after ch0 was served: ch1 goes first, then ch0
        expect_rec(8'hA1, 8'h44);
        expect_rec(8'hA0, 8'h33);
        strobe(1'b1, 8'h33, 1'b1, 8'h44);
        drain("drain_tie_after_ch0");

        // Overfill ch1 while disabled, then drain in push order
        enable = 1'b0;
        @(negedge fifo_clk);
        for (int i = 0; i < 10; i++) begin
            ch1_valid = 1'b1; ch1_data = 8'h30 + 8'(i);
            @(negedge fifo_clk);
        end
        ch1_valid = 1'b0;
        check("drop_cnt1_after_10", drop_cnt1, 8'd2);
        check("no_tx_while_disabled", tx_start, 0);
        expect_rec(8'hB1, 8'h30);
        for (int i = 1; i < 8; i++) expect_rec(8'hA1, 8'h30 + 8'(i));
        enable = 1'b1;
        drain("drain_ch1_backlog");
        check("drop_cnt1_held", drop_cnt1, 8'd2);

        // UART busy for 20 cycles after the tag holds back the data byte
        expect_rec(8'hA0, 8'h77);
        strobe(1'b1, 8'h77, 1'b0, 8'h00);
        wait_tx("busy_tag_seen");
        uart_busy = 1'b1;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fifo_clk);
            if (tx_start) early++;
        end
        check("no_tx_while_busy", early, 0);
        check("data_pending_while_busy", exp_q.size(), 1);
        uart_busy = 1'b0;
        drain("drain_after_busy");

        // Reset in WAIT_T with three ch0 bytes still queued
        enable = 1'b0;
        for (int i = 0; i < 4; i++) strobe(1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00);
        exp_q.push_back(8'hA0);
        enable = 1'b1;
        wait_tx("rst_mid_tag_seen");
        uart_busy = 1'b1;
        repeat (3) @(negedge fifo_clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_tx_data", tx_data, 8'h00);
        check("rst_mid_tag_consumed", exp_q.size(), 0);
        exp_q.delete();
        @(negedge fifo_clk);
        reset_n = 1'b1;
        uart_busy = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge fifo_clk);
            if (tx_start) seen++;
        end
        check("no_tx_after_reset", seen, 0);

        // First tie after reset favours ch0; the next tie alternates back
        expect_rec(8'hA0, 8'h11);
        expect_rec(8'hA1, 8'h22);
        strobe(1'b1, 8'h11, 1'b1, 8'h22);
        drain("drain_tie_after_reset");
        expect_rec(8'hA0, 8'h55);
        expect_rec(8'hA1, 8'h66);
        strobe(1'b1, 8'h55, 1'b1, 8'h66);
        drain("drain_second_tie");

        // Saturating drop counter: 8 accepted then 292 dropped
        enable = 1'b0;
        @(negedge fifo_clk);
        ch0_valid = 1'b1; ch0_data = 8'hEE;
        repeat (262) @(negedge fifo_clk);
        check("drop_cnt0_254", drop_cnt0, 8'hFE);
        @(negedge fifo_clk);
        check("drop_cnt0_255", drop_cnt0, 8'hFF);
        repeat (37) @(negedge fifo_clk);
        ch0_valid = 1'b0;
        check("drop_cnt0_saturated", drop_cnt0, 8'hFF);
        check("drop_cnt1_untouched", drop_cnt1, 8'd0);
        do_reset();
        check("drop_cnt0_cleared", drop_cnt0, 8'h00);
        enable = 1'b1;
        repeat (10) @(negedge fifo_clk);
        check("fifo_empty_after_reset", tx_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
